mem_seq_ctrl: RTL and testbench

- Command sequencer for the small byte-wide register memory on the USB research datapath.
- Parses a host byte stream into write/read frames and drives a simple memory port (addr, wdata, we, re).
- Returns read data and a status byte on an outbound stream, and owns the bus-direction control (tx_oe_o) for the shared 8-bit inout bus.

---
 rtl/mem_seq_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_mem_seq_ctrl.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_seq_ctrl.sv
// Command sequencer: parses CMD/ADDR/LEN/payload frames from a byte stream into memory-port strobes and returns read data plus a status byte.
// Optional inter-byte abort timer is enabled with MEM_SEQ_TIMEOUT_EN; without it timeout_o is constant 0.
module mem_seq_ctrl #(
    parameter int DEPTH          = 5,
    parameter int AW             = 3,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [7:0]    rx_data_i,
    input  logic          rx_valid_i,
    output logic          rx_ready_o,
    output logic [7:0]    tx_data_o,
    output logic          tx_valid_o,
    input  logic          tx_ready_i,
    output logic          tx_oe_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [7:0]    mem_wdata_o,
    output logic          mem_we_o,
    output logic          mem_re_o,
    input  logic [7:0]    mem_rdata_i,
    output logic          busy_o,
    output logic          timeout_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_GET_ADDR, S_GET_LEN, S_WR_DATA,
        S_RD_ISSUE, S_RD_WAIT, S_RD_SEND, S_STATUS
    } state_e;

    localparam logic [7:0] CMD_WR = 8'hFF;
    localparam logic [7:0] CMD_RD = 8'hAA;
    localparam logic [7:0] ST_OK  = 8'h5A;
    localparam logic [7:0] ST_ERR = 8'hE5;

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    len_q, len_d;
    logic          isRead_q, isRead_d;
    logic          err_q, err_d;
    logic [7:0]    wdata_q, wdata_d;
    logic          we_q, we_d;
    logic [7:0]    txData_q, txData_d;
    logic          oe_q, oe_d;
    logic          timeout_q, timeout_d;

    logic          rxReady, txValid, rxFire, txFire, abort;
    logic [AW-1:0] addrInc;

    assign rxFire  = rx_valid_i && rxReady;
    assign txFire  = txValid && tx_ready_i;
    // Wrap at DEPTH rather than at 2^AW so a frame never walks into unmapped space.
    assign addrInc = (addr_q == AW'(DEPTH - 1)) ? '0 : addr_q + AW'(1);

`ifdef MEM_SEQ_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] toCnt_q, toCnt_d;
    logic          waitState;

    always_comb begin
        waitState = (state_q == S_GET_ADDR) || (state_q == S_GET_LEN) || (state_q == S_WR_DATA);
        abort     = waitState && !rxFire && (toCnt_q == CW'(TIMEOUT_CYCLES - 1));
        toCnt_d   = '0;
        if (waitState && !rxFire && !abort) begin
            toCnt_d = toCnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            toCnt_q <= '0;
        end else begin
            toCnt_q <= toCnt_d;
        end
    end
`else
    logic unusedTimeout;
    assign unusedTimeout = ^TIMEOUT_CYCLES;
    assign abort         = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            len_q     <= '0;
            isRead_q  <= 1'b0;
            err_q     <= 1'b0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            txData_q  <= '0;
            oe_q      <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            isRead_q  <= isRead_d;
            err_q     <= err_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            txData_q  <= txData_d;
            oe_q      <= oe_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        len_d     = len_q;
        isRead_d  = isRead_q;
        err_d     = err_q;
        wdata_d   = wdata_q;
        we_d      = 1'b0;
        txData_d  = txData_q;
        oe_d      = oe_q;
        timeout_d = abort;
        // The write strobe uses the address of the byte just accepted, so advance only once it has fired.
        if (we_q) begin
            addr_d = addrInc;
        end
        unique case (state_q)
            S_IDLE: begin
                if (rxFire && (rx_data_i == CMD_WR || rx_data_i == CMD_RD)) begin
                    isRead_d = (rx_data_i == CMD_RD);
                    err_d    = 1'b0;
                    state_d  = S_GET_ADDR;
                end
            end
            S_GET_ADDR: begin
                if (rxFire) begin
                    err_d   = (rx_data_i >= 8'(DEPTH));
                    addr_d  = err_d ? '0 : rx_data_i[AW-1:0];
                    state_d = S_GET_LEN;
                end
            end
            S_GET_LEN: begin
                if (rxFire) begin
                    len_d = rx_data_i;
                    if (rx_data_i == 8'd0) begin
                        state_d = S_STATUS;
                    end else if (isRead_q) begin
                        state_d = S_RD_ISSUE;
                    end else begin
                        state_d = S_WR_DATA;
                    end
                end
            end
            S_WR_DATA: begin
                if (rxFire) begin
                    wdata_d = rx_data_i;
                    we_d    = !err_q;
                    len_d   = len_q - 8'd1;
                    if (len_q == 8'd1) begin
                        state_d = S_STATUS;
                    end
                end
            end
            S_RD_ISSUE: state_d = S_RD_WAIT;
            S_RD_WAIT: begin
                txData_d = err_q ? 8'h00 : mem_rdata_i;
                state_d  = S_RD_SEND;
            end
            S_RD_SEND: begin
                oe_d = 1'b1;
                if (txFire) begin
                    addr_d  = addrInc;
                    len_d   = len_q - 8'd1;
                    state_d = (len_q == 8'd1) ? S_STATUS : S_RD_ISSUE;
                end
            end
            S_STATUS: begin
                oe_d = 1'b1;
                if (txFire) begin
                    oe_d    = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (abort) begin
            state_d = S_IDLE;
        end
    end

    always_comb begin
        rxReady   = 1'b0;
        txValid   = 1'b0;
        tx_data_o = 8'h00;
        mem_re_o  = 1'b0;
        case (state_q)
            S_IDLE, S_GET_ADDR, S_GET_LEN, S_WR_DATA: rxReady = 1'b1;
            S_RD_ISSUE: mem_re_o = !err_q;
            S_RD_SEND: begin
                txValid   = 1'b1;
                tx_data_o = txData_q;
            end
            S_STATUS: begin
                txValid   = 1'b1;
                tx_data_o = err_q ? ST_ERR : ST_OK;
            end
            default: ;
        endcase
        // Reset masks every strobe and handshake during the reset cycle itself.
        if (rst_i) begin
            rxReady   = 1'b0;
            txValid   = 1'b0;
            tx_data_o = 8'h00;
            mem_re_o  = 1'b0;
        end
    end

    assign rx_ready_o  = rxReady;
    assign tx_valid_o  = txValid;
    assign tx_oe_o     = (oe_q || txValid) && !rst_i;
    assign mem_we_o    = we_q && !rst_i;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign busy_o      = (state_q != S_IDLE) && !rst_i;
    assign timeout_o   = timeout_q && !rst_i;

endmodule

// File: tb/tb_mem_seq_ctrl.sv
// Scoreboard bench for mem_seq_ctrl: a frame-level model queues expected tx bytes and memory strobes, a monitor pops and compares.
// The abort-timer scenario follows MEM_SEQ_TIMEOUT_EN when it is defined.
module tb_mem_seq_ctrl;

    localparam int DEPTH = 5;
    localparam int AW    = 3;
    localparam int TO    = 8;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [7:0]    rx_data_i;
    logic          rx_valid_i;
    logic          rx_ready_o;
    logic [7:0]    tx_data_o;
    logic          tx_valid_o;
    logic          tx_ready_i;
    logic          tx_oe_o;
    logic [AW-1:0] mem_addr_o;
    logic [7:0]    mem_wdata_o;
    logic          mem_we_o;
    logic          mem_re_o;
    logic [7:0]    mem_rdata_i;
    logic          busy_o;
    logic          timeout_o;

    mem_seq_ctrl #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o),
        .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
        .tx_oe_o(tx_oe_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_we_o(mem_we_o), .mem_re_o(mem_re_o), .mem_rdata_i(mem_rdata_i),
        .busy_o(busy_o), .timeout_o(timeout_o)
    );

    always #5 clk_i = ~clk_i;

    int         checks = 0;
    int         errors = 0;
    int         readyMode = 1;
    int         reCount = 0;
    logic [7:0] envMem [DEPTH];
    logic [7:0] refMem [DEPTH];
    logic [7:0] payload [8];
    logic [8:0]  txQ [$];
    logic [10:0] wrQ [$];
    logic [AW-1:0] rdQ [$];
    logic       holdPend = 1'b0;
    logic [7:0] heldData = 8'h00;
    logic       expectOeLow = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic reportMissing(input string name, input logic [31:0] actual);
        checks++;
        errors++;
        $display("[TB] FAIL %s: got 0x%0h, expected no event at %0t", name, actual, $time);
    endtask

    // Memory behind the port: synchronous write, read data valid the cycle after the strobe.
    always @(posedge clk_i) begin
        if (mem_we_o && int'(mem_addr_o) < DEPTH) envMem[mem_addr_o] <= mem_wdata_o;
        if (mem_re_o && int'(mem_addr_o) < DEPTH) mem_rdata_i <= envMem[mem_addr_o];
    end

    initial begin
        tx_ready_i = 1'b0;
        forever begin
            @(posedge clk_i);
            #1;
            case (readyMode)
                0:       tx_ready_i = ($urandom_range(0, 3) != 0);
                1:       tx_ready_i = 1'b1;
                default: tx_ready_i = 1'b0;
            endcase
        end
    end

    // Monitor: every DUT event must match the head of its expectation queue.
    always @(negedge clk_i) begin
        logic [8:0]  expTx;
        logic [10:0] expWr;
        logic [AW-1:0] expRd;
        if (rst_i) begin
            holdPend    = 1'b0;
            expectOeLow = 1'b0;
        end else begin
            if (expectOeLow) begin
                checkOutput("oeFall", 32'(tx_oe_o), 32'(0));
                expectOeLow = 1'b0;
            end
            if (holdPend) begin
                checkOutput("holdValid", 32'(tx_valid_o), 32'(1));
                checkOutput("holdData", 32'(tx_data_o), 32'(heldData));
                holdPend = 1'b0;
            end
            if (rx_ready_o) checkOutput("oeWhileRx", 32'(tx_oe_o), 32'(0));
            if (tx_valid_o) begin
                checkOutput("oeWithValid", 32'(tx_oe_o), 32'(1));
                if (tx_ready_i) begin
                    if (txQ.size() == 0) begin
                        reportMissing("unexpectedTx", 32'(tx_data_o));
                    end else begin
                        expTx = txQ.pop_front();
                        checkOutput("txData", 32'(tx_data_o), 32'(expTx[7:0]));
                        if (expTx[8]) expectOeLow = 1'b1;
                    end
                end else begin
                    holdPend = 1'b1;
                    heldData = tx_data_o;
                end
            end
            if (mem_we_o) begin
                if (wrQ.size() == 0) begin
                    reportMissing("unexpectedWrite", 32'({mem_addr_o, mem_wdata_o}));
                end else begin
                    expWr = wrQ.pop_front();
                    checkOutput("memWrite", 32'({mem_addr_o, mem_wdata_o}), 32'(expWr));
                end
            end
            if (mem_re_o) begin
                reCount++;
                if (rdQ.size() == 0) begin
                    reportMissing("unexpectedRead", 32'(mem_addr_o));
                end else begin
                    expRd = rdQ.pop_front();
                    checkOutput("memReadAddr", 32'(mem_addr_o), 32'(expRd));
                end
            end
        end
    end

    task automatic applyStimulus(input logic [7:0] b, input int weCheck);
        bit done;
        done = 1'b0;
        rx_data_i  = b;
        rx_valid_i = 1'b1;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk_i);
            if (rx_ready_o) done = 1'b1;
        end
        @(posedge clk_i);
        #1;
        rx_valid_i = 1'b0;
        if (!done) begin
            reportMissing("rxAcceptTimeout", 32'(b));
        end else if (weCheck >= 0) begin
            @(negedge clk_i);
            checkOutput("weLatency", 32'(mem_we_o), 32'(weCheck));
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic gap();
        int n;
        n = $urandom_range(0, 2);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    // Reference model: frame rules expressed with modulo arithmetic over an array.
    task automatic sendFrame(input bit isRead, input int addr, input int len);
        bit err;
        int a;
        err = (addr >= DEPTH);
        if (isRead) begin
            for (int i = 0; i < len; i++) begin
                a = (addr + i) % DEPTH;
                if (err) begin
                    txQ.push_back(9'h000);
                end else begin
                    rdQ.push_back(AW'(a));
                    txQ.push_back({1'b0, refMem[a]});
                end
            end
        end
        txQ.push_back({1'b1, err ? 8'hE5 : 8'h5A});
        applyStimulus(isRead ? 8'hAA : 8'hFF, -1);
        gap();
        applyStimulus(8'(addr), -1);
        gap();
        applyStimulus(8'(len), -1);
        if (!isRead) begin
            for (int i = 0; i < len; i++) begin
                gap();
                if (!err) begin
                    a = (addr + i) % DEPTH;
                    wrQ.push_back({AW'(a), payload[i]});
                    refMem[a] = payload[i];
                end
                applyStimulus(payload[i], err ? 0 : 1);
            end
        end
    endtask

    task automatic waitIdle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk_i);
            if (!busy_o && txQ.size() == 0 && rdQ.size() == 0 && wrQ.size() == 0) done = 1'b1;
        end
        if (!done) begin
            reportMissing("frameTimeout", 32'(txQ.size()));
            txQ.delete();
            rdQ.delete();
            wrQ.delete();
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic runFrame(input bit isRead, input int addr, input int len);
        sendFrame(isRead, addr, len);
        waitIdle();
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int reBefore;
        int pulses;
        bit seen;
        rst_i      = 1'b1;
        rx_valid_i = 1'b0;
        rx_data_i  = 8'h00;
        for (int i = 0; i < DEPTH; i++) refMem[i] = 8'h00;

        @(negedge clk_i);
        checkOutput("rxReadyInReset", 32'(rx_ready_o), 32'(0));
        checkOutput("weInReset", 32'(mem_we_o), 32'(0));
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        checkOutput("rstRxReady", 32'(rx_ready_o), 32'(1));
        checkOutput("rstBusy", 32'(busy_o), 32'(0));
        checkOutput("rstTxValid", 32'(tx_valid_o), 32'(0));
        checkOutput("rstTxOe", 32'(tx_oe_o), 32'(0));
        checkOutput("rstTxData", 32'(tx_data_o), 32'(0));
        checkOutput("rstStrobes", 32'({mem_we_o, mem_re_o, timeout_o}), 32'(0));
        checkOutput("rstAddr", 32'(mem_addr_o), 32'(0));
        @(posedge clk_i);
        #1;

        payload[0] = 8'h11;
        payload[1] = 8'h22;
        runFrame(1'b0, 2, 2);
        for (int i = 0; i < DEPTH; i++) payload[i] = 8'(i + 1);
        runFrame(1'b0, 0, 5);
        runFrame(1'b1, 4, 3);

        payload[0] = 8'h33;
        runFrame(1'b0, 7, 1);
        runFrame(1'b1, 9, 2);
        runFrame(1'b1, 3, 0);

        // Backpressure: hold the sink off while the first read byte is presented.
        readyMode = 2;
        reBefore  = reCount;
        sendFrame(1'b1, 1, 2);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk_i);
            if (tx_valid_o) seen = 1'b1;
        end
        if (!seen) reportMissing("bpNoValid", 32'(0));
        for (int i = 0; i < 10; i++) begin
            checkOutput("bpData", 32'(tx_data_o), 32'(refMem[1]));
            checkOutput("bpOe", 32'(tx_oe_o), 32'(1));
            checkOutput("bpRxReady", 32'(rx_ready_o), 32'(0));
            @(negedge clk_i);
        end
        @(posedge clk_i);
        #1;
        readyMode = 1;
        waitIdle();
        checkOutput("bpReadCount", 32'(reCount - reBefore), 32'(2));

        readyMode = 0;
        for (int f = 0; f < 25; f++) begin
            if ($urandom_range(0, 3) == 0) begin
                logic [7:0] junk;
                junk = 8'($urandom_range(0, 254));
                if (junk == 8'hAA) junk = 8'h3C;
                applyStimulus(junk, -1);
                @(negedge clk_i);
                checkOutput("junkIgnored", 32'(busy_o), 32'(0));
                @(posedge clk_i);
                #1;
            end
            for (int i = 0; i < 8; i++) payload[i] = 8'($urandom_range(0, 255));
            runFrame(1'($urandom_range(0, 1)), $urandom_range(0, 6), $urandom_range(0, 4));
        end
        readyMode = 1;

        applyStimulus(8'h00, -1);
        applyStimulus(8'h3C, -1);
        @(negedge clk_i);
        checkOutput("junkBusy", 32'(busy_o), 32'(0));
        @(posedge clk_i);
        #1;
        applyStimulus(8'hFF, -1);
        applyStimulus(8'h00, -1);
        applyStimulus(8'h03, -1);
        wrQ.push_back({AW'(0), 8'hAA});
        refMem[0] = 8'hAA;
        applyStimulus(8'hAA, 1);
        rst_i = 1'b1;
        @(negedge clk_i);
        checkOutput("midRstBusy", 32'(busy_o), 32'(0));
        checkOutput("midRstRxReady", 32'(rx_ready_o), 32'(0));
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        checkOutput("postRstBusy", 32'(busy_o), 32'(0));
        checkOutput("postRstRxReady", 32'(rx_ready_o), 32'(1));
        checkOutput("retainedMem0", 32'(envMem[0]), 32'(refMem[0]));
        repeat (5) @(negedge clk_i);
        checkOutput("noStatusAfterRst", 32'(tx_valid_o), 32'(0));
        @(posedge clk_i);
        #1;

`ifdef MEM_SEQ_TIMEOUT_EN
        applyStimulus(8'hFF, -1);
        applyStimulus(8'h01, -1);
        pulses = 0;
        seen   = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk_i);
            if (timeout_o) begin
                pulses++;
                checkOutput("toBusy", 32'(busy_o), 32'(0));
                seen = 1'b1;
            end
            if (tx_valid_o) reportMissing("toUnexpectedTx", 32'(tx_data_o));
        end
        checkOutput("toPulseCount", 32'(pulses), 32'(1));
        checkOutput("toIdle", 32'(busy_o), 32'(0));
        @(posedge clk_i);
        #1;
`else
        applyStimulus(8'hFF, -1);
        applyStimulus(8'h01, -1);
        pulses = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_i);
            if (timeout_o) pulses++;
        end
        checkOutput("noToPulses", 32'(pulses), 32'(0));
        checkOutput("stillBusy", 32'(busy_o), 32'(1));
        checkOutput("stillRxReady", 32'(rx_ready_o), 32'(1));
        @(posedge clk_i);
        #1;
        txQ.push_back({1'b1, 8'h5A});
        applyStimulus(8'h00, -1);
        waitIdle();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
